// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control sequencer: FSM states,
// opcodes, ALU operation codes and the datapath mux-select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BEQ,
    S_JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  typedef struct packed {
    logic        mem_req;
    logic        pc_write;
    logic        adr_src;
    logic        mem_write;
    logic        ir_write;
    logic        reg_write;
    result_src_t result_src;
    src_a_t      alu_src_a;
    src_b_t      alu_src_b;
    imm_src_t    imm_src;
    logic        illegal_op;
  } ctrl_t;

  function automatic logic is_store(input logic [6:0] op);
    return op == OP_SW;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bus between the multi-cycle sequencer (master) and the datapath
// plus memory (slave): instruction fields and status in, enables and selects out.
interface mc_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal_op
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct3/funct7b5 onto the ALU control code.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic      i_op5,
  input  logic [2:0] i_funct3,
  input  logic      i_funct7b5,
  input  alu_op_t   i_alu_op,
  output alu_ctrl_t o_alu_control
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves the output
    // unassigned; otherwise synthesis infers a latch.
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // Only R-type (op[5] set) may subtract; addi keeps add whatever bit 30 holds.
          3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control sequencer for the multi-cycle RV32I datapath: steps each
// instruction from FETCH through writeback and drives enables and mux selects.
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mc_control_fsm_if.master  bus
);

  state_t    r_state;
  state_t    w_next_state;
  ctrl_t     w_ctrl;
  alu_op_t   w_alu_op;
  alu_ctrl_t w_alu_control;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_ctrl       = '0;
    w_alu_op     = ALUOP_ADD;

    case (r_state)
      S_FETCH: begin
        w_ctrl.mem_req    = 1'b1;
        w_ctrl.alu_src_a  = SRCA_PC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALURESULT;
        // Instruction register and PC + 4 only commit once memory answers.
        w_ctrl.ir_write   = bus.mem_ready;
        w_ctrl.pc_write   = bus.mem_ready;
        if (bus.mem_ready) w_next_state = S_DECODE;
      end

      S_DECODE: begin
        w_ctrl.alu_src_a = SRCA_OLDPC;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.imm_src   = IMM_B;
        case (bus.op)
          OP_LW, OP_SW: w_next_state = S_MEMADR;
          OP_R:         w_next_state = S_EXECR;
          OP_I:         w_next_state = S_EXECI;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_JAL:       w_next_state = S_JAL;
          default: begin
            w_next_state      = S_FETCH;
            w_ctrl.illegal_op = 1'b1;
          end
        endcase
      end

      S_MEMADR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        if (is_store(bus.op)) begin
          w_ctrl.imm_src = IMM_S;
          w_next_state   = S_MEMWRITE;
        end else begin
          w_ctrl.imm_src = IMM_I;
          w_next_state   = S_MEMREAD;
        end
      end

      S_MEMREAD: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.adr_src = 1'b1;
        if (bus.mem_ready) w_next_state = S_MEMWB;
      end

      S_MEMWB: begin
        w_ctrl.result_src = RES_DATA;
        w_ctrl.reg_write  = 1'b1;
        w_next_state      = S_FETCH;
      end

      S_MEMWRITE: begin
        // Strobe stays high for the whole access; memory commits on mem_ready.
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.adr_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
        if (bus.mem_ready) w_next_state = S_FETCH;
      end

      S_EXECR: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_RS2;
        w_alu_op         = ALUOP_FUNCT;
        w_next_state     = S_ALUWB;
      end

      S_EXECI: begin
        w_ctrl.alu_src_a = SRCA_RS1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.imm_src   = IMM_I;
        w_alu_op         = ALUOP_FUNCT;
        w_next_state     = S_ALUWB;
      end

      S_ALUWB: begin
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.reg_write  = 1'b1;
        w_next_state      = S_FETCH;
      end

      S_BEQ: begin
        // Branch target was precomputed in DECODE and sits in ALUOut.
        w_ctrl.alu_src_a  = SRCA_RS1;
        w_ctrl.alu_src_b  = SRCB_RS2;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = bus.zero;
        w_alu_op          = ALUOP_SUB;
        w_next_state      = S_FETCH;
      end

      S_JAL: begin
        w_ctrl.alu_src_a  = SRCA_OLDPC;
        w_ctrl.alu_src_b  = SRCB_FOUR;
        w_ctrl.result_src = RES_ALUOUT;
        w_ctrl.pc_write   = 1'b1;
        w_next_state      = S_ALUWB;
      end

      default: w_next_state = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_op5         (bus.op[5]),
    .i_funct3      (bus.funct3),
    .i_funct7b5    (bus.funct7b5),
    .i_alu_op      (w_alu_op),
    .o_alu_control (w_alu_control)
  );

  // Reset is synchronous, so outputs are forced low combinationally for the
  // whole time reset is held, whatever state the register still shows.
  assign bus.mem_req     = reset ? 1'b0  : w_ctrl.mem_req;
  assign bus.pc_write    = reset ? 1'b0  : w_ctrl.pc_write;
  assign bus.adr_src     = reset ? 1'b0  : w_ctrl.adr_src;
  assign bus.mem_write   = reset ? 1'b0  : w_ctrl.mem_write;
  assign bus.ir_write    = reset ? 1'b0  : w_ctrl.ir_write;
  assign bus.reg_write   = reset ? 1'b0  : w_ctrl.reg_write;
  assign bus.result_src  = reset ? 2'b00 : w_ctrl.result_src;
  assign bus.alu_src_a   = reset ? 2'b00 : w_ctrl.alu_src_a;
  assign bus.alu_src_b   = reset ? 2'b00 : w_ctrl.alu_src_b;
  assign bus.imm_src     = reset ? 2'b00 : w_ctrl.imm_src;
  assign bus.alu_control = reset ? 3'b000 : w_alu_control;
  assign bus.illegal_op  = reset ? 1'b0  : w_ctrl.illegal_op;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: instruction-level stimulus expands into
// per-cycle expected control words; a negedge monitor compares each cycle.
module tb_mc_control_fsm;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mc_control_fsm_if bus ();

  mc_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       mem_req;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_op;
  } exp_t;

  localparam logic [6:0] C_LW  = 7'b0000011;
  localparam logic [6:0] C_SW  = 7'b0100011;
  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_I   = 7'b0010011;
  localparam logic [6:0] C_BEQ = 7'b1100011;
  localparam logic [6:0] C_JAL = 7'b1101111;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic legal(input logic [6:0] op);
    return op inside {C_LW, C_SW, C_R, C_I, C_BEQ, C_JAL};
  endfunction

  // ALU table: add/sub by bit 30 only for register-register ops.
  function automatic logic [2:0] alu_ref(input logic is_r, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'b000:  return (is_r && f7b5) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic exp_t e_fetch(input logic done);
    exp_t e = '0;
    e.mem_req = 1'b1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
    e.ir_write = done; e.pc_write = done;
    return e;
  endfunction

  function automatic exp_t e_decode(input logic bad);
    exp_t e = '0;
    e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; e.imm_src = 2'b10; e.illegal_op = bad;
    return e;
  endfunction

  function automatic exp_t e_memadr(input logic st);
    exp_t e = '0;
    e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.imm_src = st ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic exp_t e_memacc(input logic st);
    exp_t e = '0;
    e.mem_req = 1'b1; e.adr_src = 1'b1; e.mem_write = st;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic from_mem);
    exp_t e = '0;
    e.reg_write = 1'b1; e.result_src = from_mem ? 2'b01 : 2'b00;
    return e;
  endfunction

  function automatic exp_t e_exec(input logic is_r, input logic [2:0] f3, input logic f7b5);
    exp_t e = '0;
    e.alu_src_a = 2'b10; e.alu_src_b = is_r ? 2'b00 : 2'b01;
    e.alu_control = alu_ref(is_r, f3, f7b5);
    return e;
  endfunction

  function automatic exp_t e_beq(input logic z);
    exp_t e = '0;
    e.alu_src_a = 2'b10; e.alu_control = 3'b001; e.pc_write = z;
    return e;
  endfunction

  function automatic exp_t e_jal();
    exp_t e = '0;
    e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1'b1;
    return e;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue what this cycle must show.
  task automatic step(input logic rst, input logic rdy, input logic z,
                      input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                      input exp_t e, input string nm);
    @(posedge clk);
    #1;
    reset         = rst;
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.op        = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7b5;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                           input int fw, input int mw, input logic z, input string nm);
    logic st;
    st = (op == C_SW);
    for (int i = 0; i < fw; i++)
      step(1'b0, 1'b0, rb(), op, f3, f7b5, e_fetch(1'b0), {nm, " fetch-wait"});
    step(1'b0, 1'b1, rb(), op, f3, f7b5, e_fetch(1'b1), {nm, " fetch"});
    step(1'b0, rb(), rb(), op, f3, f7b5, e_decode(!legal(op)), {nm, " decode"});
    case (op)
      C_LW, C_SW: begin
        step(1'b0, rb(), rb(), op, f3, f7b5, e_memadr(st), {nm, " memadr"});
        for (int i = 0; i < mw; i++)
          step(1'b0, 1'b0, rb(), op, f3, f7b5, e_memacc(st), {nm, " mem-wait"});
        step(1'b0, 1'b1, rb(), op, f3, f7b5, e_memacc(st), {nm, " mem"});
        if (!st) step(1'b0, rb(), rb(), op, f3, f7b5, e_wb(1'b1), {nm, " memwb"});
      end
      C_R, C_I: begin
        step(1'b0, rb(), rb(), op, f3, f7b5, e_exec(op == C_R, f3, f7b5), {nm, " exec"});
        step(1'b0, rb(), rb(), op, f3, f7b5, e_wb(1'b0), {nm, " aluwb"});
      end
      C_BEQ: step(1'b0, rb(), z, op, f3, f7b5, e_beq(z), {nm, " beq"});
      C_JAL: begin
        step(1'b0, rb(), rb(), op, f3, f7b5, e_jal(), {nm, " jal"});
        step(1'b0, rb(), rb(), op, f3, f7b5, e_wb(1'b0), {nm, " aluwb"});
      end
      default: ;
    endcase
  endtask

  initial begin : monitor
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.mem_req     = bus.mem_req;
        a.pc_write    = bus.pc_write;
        a.adr_src     = bus.adr_src;
        a.mem_write   = bus.mem_write;
        a.ir_write    = bus.ir_write;
        a.reg_write   = bus.reg_write;
        a.result_src  = bus.result_src;
        a.alu_src_a   = bus.alu_src_a;
        a.alu_src_b   = bus.alu_src_b;
        a.imm_src     = bus.imm_src;
        a.alu_control = bus.alu_control;
        a.illegal_op  = bus.illegal_op;
        n_vec++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s @%0t: got %b required %b (mreq,pcw,adr,mw,irw,rw,res,sa,sb,imm,alu,ill)",
                   nm, $time, a, e);
        end
      end
    end
  end

  initial begin : stimulus
    logic [6:0] op;
    int         kind;
    reset = 1'b1;
    bus.op = '0; bus.funct3 = '0; bus.funct7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, "reset 0");
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, "reset 1");

    run_instr(C_R, 3'b000, 1'b0, 0, 0, 1'b0, "add");
    run_instr(C_R, 3'b000, 1'b1, 0, 0, 1'b0, "sub");
    run_instr(C_I, 3'b000, 1'b1, 0, 0, 1'b0, "addi-f7b5");
    run_instr(C_LW, 3'b010, 1'b0, 0, 3, 1'b0, "lw-3wait");
    run_instr(C_SW, 3'b010, 1'b0, 1, 2, 1'b0, "sw");
    run_instr(C_BEQ, 3'b000, 1'b0, 0, 0, 1'b1, "beq-taken");
    run_instr(C_BEQ, 3'b000, 1'b0, 0, 0, 1'b0, "beq-not");
    run_instr(C_JAL, 3'b000, 1'b0, 0, 0, 1'b0, "jal");
    run_instr(7'b0000000, 3'b000, 1'b0, 0, 0, 1'b0, "illegal");
    run_instr(C_R, 3'b111, 1'b0, 0, 0, 1'b0, "after-illegal");

    // Reset held two cycles while a load waits in its memory read.
    step(1'b0, 1'b1, 1'b0, C_LW, 3'b010, 1'b0, e_fetch(1'b1), "rst-lw fetch");
    step(1'b0, 1'b0, 1'b0, C_LW, 3'b010, 1'b0, e_decode(1'b0), "rst-lw decode");
    step(1'b0, 1'b0, 1'b0, C_LW, 3'b010, 1'b0, e_memadr(1'b0), "rst-lw memadr");
    step(1'b0, 1'b0, 1'b0, C_LW, 3'b010, 1'b0, e_memacc(1'b0), "rst-lw mem-wait");
    step(1'b1, 1'b1, 1'b1, C_LW, 3'b010, 1'b0, '0, "rst-lw hold 0");
    step(1'b1, 1'b1, 1'b1, C_LW, 3'b010, 1'b0, '0, "rst-lw hold 1");
    run_instr(C_R, 3'b110, 1'b0, 0, 0, 1'b0, "post-reset or");

    for (int n = 0; n < 300; n++) begin
      kind = int'($urandom_range(0, 6));
      case (kind)
        0: op = C_LW;
        1: op = C_SW;
        2: op = C_R;
        3: op = C_I;
        4: op = C_BEQ;
        5: op = C_JAL;
        default: begin
          op = 7'($urandom);
          while (legal(op)) op = 7'($urandom);
        end
      endcase
      run_instr(op, 3'($urandom), rb(), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), rb(), "rand");
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
